// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, block sizes, the inverse S-box
// and the GF(2^8) helpers (polynomial 0x11B) used by the inverse round datapath.
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0e/0b/0d/09) by summing xtime powers.
  function automatic logic [7:0] gmul_inv(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^
           (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[BLOCK_W-1-8*i -: 8] = INV_SBOX[s[BLOCK_W-1-8*i -: 8]];
    return o;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates right by r columns.
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[BLOCK_W-1-8*(r+4*c) -: 8] = s[BLOCK_W-1-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[BLOCK_W-1-32*c -: 8];
      a1 = s[BLOCK_W-9-32*c -: 8];
      a2 = s[BLOCK_W-17-32*c -: 8];
      a3 = s[BLOCK_W-25-32*c -: 8];
      o[BLOCK_W-1-32*c -: 8]  = gmul_inv(a0, 4'he) ^ gmul_inv(a1, 4'hb) ^ gmul_inv(a2, 4'hd) ^ gmul_inv(a3, 4'h9);
      o[BLOCK_W-9-32*c -: 8]  = gmul_inv(a0, 4'h9) ^ gmul_inv(a1, 4'he) ^ gmul_inv(a2, 4'hb) ^ gmul_inv(a3, 4'hd);
      o[BLOCK_W-17-32*c -: 8] = gmul_inv(a0, 4'hd) ^ gmul_inv(a1, 4'h9) ^ gmul_inv(a2, 4'he) ^ gmul_inv(a3, 4'hb);
      o[BLOCK_W-25-32*c -: 8] = gmul_inv(a0, 4'hb) ^ gmul_inv(a1, 4'hd) ^ gmul_inv(a2, 4'h9) ^ gmul_inv(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational single inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] rkey,
  input  logic               last,
  output logic [BLOCK_W-1:0] result
);

  logic [BLOCK_W-1:0] added;

  always_comb begin
    added  = inv_sub_bytes(inv_shift_rows(state)) ^ rkey;
    result = last ? added : inv_mix_columns(added);
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, fixed 12-cycle latency.
// Optional AES_INV_KEYSTALL_EN adds rkey_valid to stall the engine on a slow key store.
//
// state | meaning
// IDLE  | waiting for start, rkey_idx held at 0
// INIT  | initial AddRoundKey with round key 10
// ROUND | full inverse rounds using keys 9..1
// FINAL | last round (no InvMixColumns) with key 0, plaintext written
// DONE  | done pulse cycle, start ignored
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR        = aes_pkg::NR,
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BLOCK_W-1:0]   ciphertext,
  output logic [KEY_IDX_W-1:0] rkey_idx,
  input  logic [BLOCK_W-1:0]   rkey,
`ifdef AES_INV_KEYSTALL_EN
  input  logic                 rkey_valid,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [BLOCK_W-1:0]   plaintext
);

  state_t               fsm, fsm_nxt;
  logic [BLOCK_W-1:0]   blk, blk_nxt, pt_nxt, round_out;
  logic [KEY_IDX_W-1:0] idx_nxt;
  logic                 busy_nxt, done_nxt, key_ok;

`ifdef AES_INV_KEYSTALL_EN
  assign key_ok = rkey_valid;
`else
  assign key_ok = 1'b1;
`endif

  aes_inv_round u_round (
    .state  (blk),
    .rkey   (rkey),
    .last   (fsm == FINAL),
    .result (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      blk       <= '0;
      rkey_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plaintext <= '0;
    end else begin
      fsm       <= fsm_nxt;
      blk       <= blk_nxt;
      rkey_idx  <= idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      plaintext <= pt_nxt;
    end
  end

  // Everything holds by default, so a key stall simply skips the update.
  always_comb begin
    fsm_nxt  = fsm;
    blk_nxt  = blk;
    idx_nxt  = rkey_idx;
    busy_nxt = busy;
    done_nxt = 1'b0;
    pt_nxt   = plaintext;
    case (fsm)
      IDLE: begin
        if (start) begin
          blk_nxt  = ciphertext;
          idx_nxt  = KEY_IDX_W'(NR);
          busy_nxt = 1'b1;
          fsm_nxt  = INIT;
        end
      end
      INIT: begin
        if (key_ok) begin
          blk_nxt = blk ^ rkey;
          idx_nxt = KEY_IDX_W'(NR - 1);
          fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        if (key_ok) begin
          blk_nxt = round_out;
          idx_nxt = rkey_idx - KEY_IDX_W'(1);
          if (rkey_idx == KEY_IDX_W'(1))
            fsm_nxt = FINAL;
        end
      end
      FINAL: begin
        if (key_ok) begin
          pt_nxt   = round_out;
          done_nxt = 1'b1;
          fsm_nxt  = DONE;
        end
      end
      DONE: begin
        busy_nxt = 1'b0;
        fsm_nxt  = IDLE;
      end
      default: begin
        fsm_nxt  = IDLE;
        idx_nxt  = '0;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: known-answer table, handshake corner
// cases, mid-operation reset and a round trip against a behavioural encrypt model.
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] ciphertext, rkey, plaintext;
  logic [3:0]   rkey_idx;
  logic         busy, done;
`ifdef AES_INV_KEYSTALL_EN
  logic         rkey_valid;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]   ref_sbox [256];
  logic [127:0] rk [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  always_comb rkey = (rkey_idx <= 4'd10) ? rk[rkey_idx] : 128'h0;

  aes_inv_cipher dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .rkey_idx   (rkey_idx),
    .rkey       (rkey),
`ifdef AES_INV_KEYSTALL_EN
    .rkey_valid (rkey_valid),
`endif
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = ref_sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gf_mul(a[r], 8'h02) ^ gf_mul(a[(r+1)%4], 8'h03) ^
                                a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r != 10) s = mix_columns(s);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Launch one block, wait (bounded) for done, then step into IDLE.
  task automatic run_block(input logic [127:0] ct, input bit detail,
                           output logic [127:0] pt_out, output int lat);
    ciphertext = ct;
    start      = 1'b1;
    lat        = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (detail) begin
        check("busy_during_op", 128'(busy), 128'(1'b1));
        check("rkey_idx_seq", 128'(rkey_idx), 128'((k <= 11) ? 11 - k : 0));
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    pt_out = plaintext;
    tick();
    if (detail) begin
      check("busy_after_done", 128'(busy), 128'(1'b0));
      check("done_one_cycle", 128'(done), 128'(1'b0));
    end
  endtask

  initial begin : main
    logic [127:0] got, pt2, ct2, key, pt, ct;
    int lat, hits;

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{key: 128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                pt:  128'h0};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                pt:  128'h6bc1bee22e409f96e93d7e117393172a};

    rst        = 1'b1;
    start      = 1'b0;
    ciphertext = '0;
`ifdef AES_INV_KEYSTALL_EN
    rkey_valid = 1'b1;
`endif

    // Forward S-box from first principles: affine transform of the GF inverse.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int r = 0; r < 11; r++) rk[r] = '0;

    repeat (3) tick();
    check("reset_busy", 128'(busy), 128'(1'b0));
    check("reset_done", 128'(done), 128'(1'b0));
    check("reset_idx", 128'(rkey_idx), 128'(0));
    check("reset_pt", plaintext, 128'h0);
    rst = 1'b0;
    tick();
    check("idle_idx", 128'(rkey_idx), 128'(0));

    expand_key(vecs[0].key);
    check("model_c1", encrypt(vecs[0].pt), vecs[0].ct);

    for (int v = 0; v < 4; v++) begin
      expand_key(vecs[v].key);
      run_block(vecs[v].ct, 1'b1, got, lat);
      check($sformatf("vec%0d_pt", v), got, vecs[v].pt);
      check($sformatf("vec%0d_latency", v), 128'(lat), 128'(12));
    end

    // start held high: accepts every 13 cycles; second ct captured at re-accept.
    expand_key(vecs[0].key);
    pt2 = 128'hffeeddccbbaa99887766554433221100;
    ct2 = encrypt(pt2);
    ciphertext = vecs[0].ct;
    start      = 1'b1;
    for (int j = 1; j <= 39; j++) begin
      tick();
      if (j == 1) ciphertext = ct2;
      check($sformatf("held_done_c%0d", j), 128'(done), 128'(j == 12 || j == 25 || j == 38));
      if (j >= 12 && j < 25) check("held_pt_first", plaintext, vecs[0].pt);
      if (j >= 25) check("held_pt_second", plaintext, pt2);
    end
    start = 1'b0;
    tick();
    check("held_idle_busy", 128'(busy), 128'(1'b0));

    // Reset in the middle of an operation.
    ciphertext = vecs[0].ct;
    start      = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 128'(busy), 128'(1'b0));
    check("midrst_done", 128'(done), 128'(1'b0));
    check("midrst_pt", plaintext, 128'h0);
    check("midrst_idx", 128'(rkey_idx), 128'(0));
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || busy) hits++;
    end
    check("midrst_no_done", 128'(hits), 128'(0));

`ifdef AES_INV_KEYSTALL_EN
    ciphertext = vecs[0].ct;
    start      = 1'b1;
    lat        = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 3) rkey_valid = 1'b0;
      if (k == 6) rkey_valid = 1'b1;
      if (k >= 3 && k <= 15) check("stall_busy", 128'(busy), 128'(1'b1));
      if (done) begin
        lat = k;
        break;
      end
    end
    check("stall_latency", 128'(lat), 128'(15));
    check("stall_pt", plaintext, vecs[0].pt);
    tick();
`endif

    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      ct = encrypt(pt);
      run_block(ct, 1'b0, got, lat);
      check($sformatf("roundtrip_%0d", i), got, pt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
